iobuf_bank: RTL and testbench

Parametrised bank of bidirectional I/O channels that sequences the 74LVC level-shifting buffers on the Bus Pirate I/O header (MOSI, CLOCK, MISO, CS, AUX, and further pins on wider builds). Each channel owns its buffer's direction, open-drain and data lines. It performs break-before-make direction turnaround and synchronises pin input. It detects sustained contention and places the channel in a safe input-only fault state. Sits between protocol engines/register file and the top-level tristate pads.

---
 rtl/iobuf_bank_pkg.sv | 19 +
 rtl/iobuf_bank_if.sv | 31 +++
 rtl/iobuf_chan.sv | 140 ++++++++++++++
 rtl/iobuf_bank.sv | 59 +++++
 tb/tb_iobuf_bank.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iobuf_bank_pkg.sv
// Shared types and helpers for the I/O buffer bank: channel state
// enumeration and a counter-width helper for the per-channel counters.
package iobuf_bank_pkg;

  // Per-channel sequencing states.
  typedef enum logic [2:0] {
    ST_IN       = 3'd0,
    ST_TURN_OUT = 3'd1,
    ST_DRIVE    = 3'd2,
    ST_TURN_IN  = 3'd3,
    ST_FAULT    = 3'd4
  } chan_state_t;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/iobuf_bank_if.sv
// Buffer-facing bundle of the I/O bank: direction, open-drain and the
// FPGA-side data/enable towards the level shifters, plus the pad readback.
interface iobuf_bank_if #(
  parameter int CHANNELS = 5
);

  logic [CHANNELS-1:0] bufdir;
  logic [CHANNELS-1:0] bufod;
  logic [CHANNELS-1:0] bufio_o;
  logic [CHANNELS-1:0] bufio_oe;
  logic [CHANNELS-1:0] bufio_i;

  // The bank drives the buffers and reads the pads.
  modport master (
    output bufdir,
    output bufod,
    output bufio_o,
    output bufio_oe,
    input  bufio_i
  );

  // Pad/buffer side: observes controls, returns pin level.
  modport slave (
    input  bufdir,
    input  bufod,
    input  bufio_o,
    input  bufio_oe,
    output bufio_i
  );

endinterface

// File: rtl/iobuf_chan.sv
// One bidirectional I/O channel: break-before-make direction sequencing,
// pin input synchroniser, expected-value pipeline and contention filter
// that drops the channel into an input-only fault state.
module iobuf_chan
  import iobuf_bank_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TURN_CYCLES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic dir_req,
  input  logic od_req,
  input  logic dout,
  input  logic fault_clr,
  input  logic pin_i,
  output logic din,
  output logic busy,
  output logic contention,
  output logic bufdir,
  output logic bufod,
  output logic bufio_o,
  output logic bufio_oe
);

  localparam int TW = cnt_width(TURN_CYCLES);
  localparam int MW = cnt_width(FILTER_LEN);
  localparam int RW = cnt_width(SYNC_STAGES);

  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);
  localparam logic [MW-1:0] MIS_LAST  = MW'(FILTER_LEN - 1);
  localparam logic [MW-1:0] MIS_MAX   = MW'(FILTER_LEN);
  localparam logic [RW-1:0] RES_MAX   = RW'(SYNC_STAGES);

  chan_state_t state_reg, state_next;
  logic [TW-1:0] turn_cnt_reg, turn_cnt_next;
  logic [MW-1:0] mis_cnt_reg, mis_cnt_next;
  logic [RW-1:0] res_cnt_reg, res_cnt_next;
  logic          o_reg, od_reg;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] exp_o_reg;
  logic [SYNC_STAGES-1:0] exp_od_reg;

  logic exp_val, exp_od, check_en, mismatch;

  // The expected pipeline has the same depth as the synchroniser, so the
  // oldest entries of both describe the same bus cycle.
  assign din      = sync_reg[SYNC_STAGES-1];
  assign exp_val  = exp_o_reg[SYNC_STAGES-1];
  assign exp_od   = exp_od_reg[SYNC_STAGES-1];
  // Only compare once the pipelines hold values driven in this DRIVE stay.
  assign check_en = (state_reg == ST_DRIVE) && (res_cnt_reg == RES_MAX);
  // An open-drain high is a release; whatever the pin does then is legal.
  assign mismatch = check_en && (din != exp_val) && !(exp_od && exp_val);

  assign bufdir     = (state_reg == ST_TURN_OUT) || (state_reg == ST_DRIVE) ||
                      (state_reg == ST_TURN_IN);
  assign bufio_oe   = (state_reg == ST_DRIVE);
  assign busy       = (state_reg == ST_TURN_OUT) || (state_reg == ST_TURN_IN);
  assign contention = (state_reg == ST_FAULT);
  assign bufio_o    = o_reg;
  assign bufod      = od_reg;

  // Next-state, turnaround timing and filter counters.
  always_comb begin
    state_next    = state_reg;
    turn_cnt_next = turn_cnt_reg;
    mis_cnt_next  = '0;
    res_cnt_next  = '0;
    case (state_reg)
      ST_IN: begin
        if (dir_req) begin
          state_next    = ST_TURN_OUT;
          turn_cnt_next = '0;
        end
      end
      ST_TURN_OUT: begin
        if (turn_cnt_reg == TURN_LAST) state_next = ST_DRIVE;
        else turn_cnt_next = turn_cnt_reg + TW'(1);
      end
      ST_DRIVE: begin
        // A fault outranks a concurrent direction change.
        if (mismatch && (mis_cnt_reg == MIS_LAST)) begin
          state_next = ST_FAULT;
        end else if (!dir_req) begin
          state_next    = ST_TURN_IN;
          turn_cnt_next = '0;
        end
      end
      ST_TURN_IN: begin
        if (turn_cnt_reg == TURN_LAST) state_next = ST_IN;
        else turn_cnt_next = turn_cnt_reg + TW'(1);
      end
      ST_FAULT: begin
        if (fault_clr) state_next = ST_IN;
      end
      default: state_next = ST_IN;
    endcase

    if ((state_next == ST_DRIVE) && mismatch)
      mis_cnt_next = (mis_cnt_reg == MIS_MAX) ? MIS_MAX : mis_cnt_reg + MW'(1);

    if (state_reg == ST_DRIVE)
      res_cnt_next = (res_cnt_reg == RES_MAX) ? RES_MAX : res_cnt_reg + RW'(1);
  end

  // State, counters and driven data; data is forced low outside DRIVE.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg    <= ST_IN;
      turn_cnt_reg <= '0;
      mis_cnt_reg  <= '0;
      res_cnt_reg  <= '0;
      o_reg        <= 1'b0;
      od_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      turn_cnt_reg <= turn_cnt_next;
      mis_cnt_reg  <= mis_cnt_next;
      res_cnt_reg  <= res_cnt_next;
      o_reg        <= (state_next == ST_DRIVE) ? dout   : 1'b0;
      od_reg       <= (state_next == ST_DRIVE) ? od_req : 1'b0;
    end
  end

  // Pin synchroniser and the matching delay line of what was driven.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_reg   <= '0;
      exp_o_reg  <= '0;
      exp_od_reg <= '0;
    end else begin
      sync_reg   <= {sync_reg[SYNC_STAGES-2:0], pin_i};
      exp_o_reg  <= {exp_o_reg[SYNC_STAGES-2:0], o_reg};
      exp_od_reg <= {exp_od_reg[SYNC_STAGES-2:0], od_reg};
    end
  end

endmodule

// File: rtl/iobuf_bank.sv
// Bank of independent I/O channels sitting between the protocol engines
// and the level-shifter pads. Each channel is a separate iobuf_chan; the
// pad-facing signals are gathered here onto the buffer interface.
module iobuf_bank
  import iobuf_bank_pkg::*;
#(
  parameter int CHANNELS    = 5,
  parameter int SYNC_STAGES = 2,
  parameter int TURN_CYCLES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] dir_req,
  input  logic [CHANNELS-1:0] od_req,
  input  logic [CHANNELS-1:0] dout,
  input  logic [CHANNELS-1:0] fault_clr,
  output logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] contention,
  iobuf_bank_if.master        pad
);

  logic [CHANNELS-1:0] bufdir_w;
  logic [CHANNELS-1:0] bufod_w;
  logic [CHANNELS-1:0] bufio_o_w;
  logic [CHANNELS-1:0] bufio_oe_w;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      iobuf_chan #(
        .SYNC_STAGES (SYNC_STAGES),
        .TURN_CYCLES (TURN_CYCLES),
        .FILTER_LEN  (FILTER_LEN)
      ) u_chan (
        .clock      (clock),
        .reset      (reset),
        .dir_req    (dir_req[gi]),
        .od_req     (od_req[gi]),
        .dout       (dout[gi]),
        .fault_clr  (fault_clr[gi]),
        .pin_i      (pad.bufio_i[gi]),
        .din        (din[gi]),
        .busy       (busy[gi]),
        .contention (contention[gi]),
        .bufdir     (bufdir_w[gi]),
        .bufod      (bufod_w[gi]),
        .bufio_o    (bufio_o_w[gi]),
        .bufio_oe   (bufio_oe_w[gi])
      );
    end
  endgenerate

  assign pad.bufdir   = bufdir_w;
  assign pad.bufod    = bufod_w;
  assign pad.bufio_o  = bufio_o_w;
  assign pad.bufio_oe = bufio_oe_w;

endmodule

// File: tb/tb_iobuf_bank.sv
// Bench for iobuf_bank: a behavioural pin/buffer model closes the loop from
// bufio_o/bufio_oe back to bufio_i, a cycle-level reference of the channel
// rules predicts every output, and directed scenarios pin down the timing.
module tb_iobuf_bank;

  localparam int CH = 5;
  localparam int SS = 2;
  localparam int TC = 2;
  localparam int FL = 8;

  localparam int M_IN  = 0;
  localparam int M_OUT = 1;
  localparam int M_DRV = 2;
  localparam int M_RET = 3;
  localparam int M_FLT = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [CH-1:0] dir_req   = '0;
  logic [CH-1:0] od_req    = '0;
  logic [CH-1:0] dout      = '0;
  logic [CH-1:0] fault_clr = '0;
  logic [CH-1:0] din, busy, contention;

  // Environment: an external driver can force the pin, otherwise an idle
  // pin floats to ext_val.
  logic [CH-1:0] force_en  = '0;
  logic [CH-1:0] force_val = '0;
  logic [CH-1:0] ext_val   = '0;

  int err_cnt = 0;
  int chk_cnt = 0;
  int cyc     = 0;

  iobuf_bank_if #(.CHANNELS(CH)) pad_if ();

  iobuf_bank #(
    .CHANNELS    (CH),
    .SYNC_STAGES (SS),
    .TURN_CYCLES (TC),
    .FILTER_LEN  (FL)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .dir_req    (dir_req),
    .od_req     (od_req),
    .dout       (dout),
    .fault_clr  (fault_clr),
    .din        (din),
    .busy       (busy),
    .contention (contention),
    .pad        (pad_if.master)
  );

  always #5 clock = ~clock;

  // Pin level seen through the buffer: forced value wins, a driven pin
  // follows the FPGA (open-drain high is a pulled-up release), else floats.
  function automatic logic pin_level(input logic oe, input logic o, input logic od,
                                     input logic fe, input logic fv, input logic ev);
    if (fe) return fv;
    if (oe) return (od && o) ? 1'b1 : o;
    return ev;
  endfunction

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_pin
      assign pad_if.bufio_i[gi] = pin_level(pad_if.bufio_oe[gi], pad_if.bufio_o[gi],
                                            pad_if.bufod[gi], force_en[gi],
                                            force_val[gi], ext_val[gi]);
    end
  endgenerate

  // ---------------- reference model ----------------
  int mode_m  [CH];
  int left_m  [CH];
  int run_m   [CH];
  int resid_m [CH];
  bit o_m     [CH];
  bit od_m    [CH];
  bit sync_m  [CH][SS];
  bit eo_m    [CH][SS];
  bit eod_m   [CH][SS];

  task automatic model_clear();
    for (int i = 0; i < CH; i++) begin
      mode_m[i] = M_IN; left_m[i] = 0; run_m[i] = 0; resid_m[i] = 0;
      o_m[i] = 1'b0; od_m[i] = 1'b0;
      for (int k = 0; k < SS; k++) begin
        sync_m[i][k] = 1'b0; eo_m[i][k] = 1'b0; eod_m[i][k] = 1'b0;
      end
    end
  endtask

  task automatic model_update(input logic [CH-1:0] pin_m);
    if (!reset) begin
      model_clear();
      return;
    end
    for (int i = 0; i < CH; i++) begin
      bit seen, want, want_od, mism;
      int nmode, nleft;
      seen    = sync_m[i][SS-1];
      want    = eo_m[i][SS-1];
      want_od = eod_m[i][SS-1];
      mism    = (mode_m[i] == M_DRV) && (resid_m[i] >= SS) && (seen != want) &&
                !(want_od && want);
      nmode = mode_m[i];
      nleft = left_m[i];
      case (mode_m[i])
        M_IN:  if (dir_req[i]) begin nmode = M_OUT; nleft = TC; end
        M_OUT: begin nleft = left_m[i] - 1; if (nleft == 0) nmode = M_DRV; end
        M_DRV: begin
          if (mism && (run_m[i] + 1 >= FL)) nmode = M_FLT;
          else if (!dir_req[i]) begin nmode = M_RET; nleft = TC; end
        end
        M_RET: begin nleft = left_m[i] - 1; if (nleft == 0) nmode = M_IN; end
        default: if (fault_clr[i]) nmode = M_IN;
      endcase
      run_m[i]   = (nmode == M_DRV && mism) ? ((run_m[i] + 1 > FL) ? FL : run_m[i] + 1) : 0;
      resid_m[i] = (mode_m[i] == M_DRV) ? ((resid_m[i] + 1 > SS) ? SS : resid_m[i] + 1) : 0;
      for (int k = SS - 1; k > 0; k--) begin
        sync_m[i][k] = sync_m[i][k-1];
        eo_m[i][k]   = eo_m[i][k-1];
        eod_m[i][k]  = eod_m[i][k-1];
      end
      sync_m[i][0] = pin_m[i];
      eo_m[i][0]   = o_m[i];
      eod_m[i][0]  = od_m[i];
      o_m[i]    = (nmode == M_DRV) ? dout[i]   : 1'b0;
      od_m[i]   = (nmode == M_DRV) ? od_req[i] : 1'b0;
      mode_m[i] = nmode;
      left_m[i] = nleft;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    chk_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, want);
    end
  endtask

  task automatic compare_all();
    logic [CH-1:0] e_dir, e_od, e_o, e_oe, e_busy, e_cont, e_din;
    for (int i = 0; i < CH; i++) begin
      e_dir[i]  = (mode_m[i] == M_OUT) || (mode_m[i] == M_DRV) || (mode_m[i] == M_RET);
      e_oe[i]   = (mode_m[i] == M_DRV);
      e_busy[i] = (mode_m[i] == M_OUT) || (mode_m[i] == M_RET);
      e_cont[i] = (mode_m[i] == M_FLT);
      e_o[i]    = o_m[i];
      e_od[i]   = od_m[i];
      e_din[i]  = sync_m[i][SS-1];
    end
    check_val("bufdir",     32'(pad_if.bufdir),   32'(e_dir));
    check_val("bufod",      32'(pad_if.bufod),    32'(e_od));
    check_val("bufio_o",    32'(pad_if.bufio_o),  32'(e_o));
    check_val("bufio_oe",   32'(pad_if.bufio_oe), 32'(e_oe));
    check_val("busy",       32'(busy),            32'(e_busy));
    check_val("contention", 32'(contention),      32'(e_cont));
    check_val("din",        32'(din),             32'(e_din));
  endtask

  // One clock: sample environment from the model, advance it, compare.
  task automatic step();
    logic [CH-1:0] pin_m;
    for (int i = 0; i < CH; i++)
      pin_m[i] = pin_level(mode_m[i] == M_DRV, o_m[i], od_m[i],
                           force_en[i], force_val[i], ext_val[i]);
    @(posedge clock);
    cyc++;
    model_update(pin_m);
    #1;
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_clear();

    // Reset state.
    reset = 1'b0;
    steps(3);
    check_val("rst_bufdir", 32'(pad_if.bufdir), 32'd0);
    check_val("rst_oe", 32'(pad_if.bufio_oe), 32'd0);
    check_val("rst_cont", 32'(contention), 32'd0);
    $display("reset: outputs idle");
    reset = 1'b1;
    steps(6);

    // Output turnaround on channel 0.
    dir_req[0] = 1'b1;
    step();
    check_val("to_bufdir0", 32'(pad_if.bufdir[0]), 32'd1);
    check_val("to_oe0_a", 32'(pad_if.bufio_oe[0]), 32'd0);
    check_val("to_busy0_a", 32'(busy[0]), 32'd1);
    step();
    check_val("to_busy0_b", 32'(busy[0]), 32'd1);
    check_val("to_oe0_b", 32'(pad_if.bufio_oe[0]), 32'd0);
    step();
    check_val("to_oe0_c", 32'(pad_if.bufio_oe[0]), 32'd1);
    check_val("to_busy0_c", 32'(busy[0]), 32'd0);
    $display("ch0 turn-out: bufdir then oe after %0d cycles", TC);

    // Push-pull echo, no contention.
    dout[0] = 1'b1;
    steps(50);
    check_val("echo_cont0", 32'(contention[0]), 32'd0);
    check_val("echo_din0", 32'(din[0]), 32'd1);
    $display("ch0 echo 50 cycles: din=%0b contention=%0b", din[0], contention[0]);

    // Pin forced low against a driven 1: fault after SS+FL cycles.
    force_en[0] = 1'b1; force_val[0] = 1'b0;
    steps(SS + FL - 1);
    check_val("ct_pre0", 32'(contention[0]), 32'd0);
    step();
    check_val("ct_cont0", 32'(contention[0]), 32'd1);
    check_val("ct_oe0", 32'(pad_if.bufio_oe[0]), 32'd0);
    check_val("ct_dir0", 32'(pad_if.bufdir[0]), 32'd0);
    $display("ch0 contention: fault raised, pad released");

    // Clear with dir_req still set: IN, then TURN_OUT.
    force_en[0] = 1'b0;
    fault_clr[0] = 1'b1;
    step();
    fault_clr[0] = 1'b0;
    check_val("clr_cont0", 32'(contention[0]), 32'd0);
    check_val("clr_dir0", 32'(pad_if.bufdir[0]), 32'd0);
    step();
    check_val("clr_rto0", 32'(pad_if.bufdir[0]), 32'd1);
    check_val("clr_busy0", 32'(busy[0]), 32'd1);
    $display("ch0 fault_clr: back to input, turn-out restarted");

    // Open-drain on channel 1: released high is not checked.
    dir_req[1] = 1'b1; od_req[1] = 1'b1; dout[1] = 1'b1;
    steps(4);
    force_en[1] = 1'b1; force_val[1] = 1'b0;
    steps(100);
    check_val("od_hi_cont1", 32'(contention[1]), 32'd0);
    dout[1] = 1'b0; force_val[1] = 1'b1;
    steps(SS + FL);
    check_val("od_lo_pre1", 32'(contention[1]), 32'd0);
    step();
    check_val("od_lo_cont1", 32'(contention[1]), 32'd1);
    $display("ch1 open-drain: high release ignored, low contention faulted");

    // Channel 2: 7 mismatches, one match, 7 more -> no fault.
    dir_req[2] = 1'b1; dout[2] = 1'b1;
    steps(6);
    force_en[2] = 1'b1; force_val[2] = 1'b0;
    steps(FL - 1);
    force_en[2] = 1'b0;
    step();
    force_en[2] = 1'b1;
    steps(FL - 1);
    force_en[2] = 1'b0;
    steps(6);
    check_val("run_cont2", 32'(contention[2]), 32'd0);
    $display("ch2 split mismatch runs: contention=%0b", contention[2]);

    // Reset during TURN_IN on ch3 while ch1 sits in FAULT.
    dir_req[3] = 1'b1;
    steps(4);
    dir_req[3] = 1'b0;
    step();
    check_val("ti_busy3", 32'(busy[3]), 32'd1);
    check_val("ti_dir3", 32'(pad_if.bufdir[3]), 32'd1);
    check_val("ti_flt1", 32'(contention[1]), 32'd1);
    reset = 1'b0;
    step();
    check_val("mr_bufdir", 32'(pad_if.bufdir), 32'd0);
    check_val("mr_oe", 32'(pad_if.bufio_oe), 32'd0);
    check_val("mr_o", 32'(pad_if.bufio_o), 32'd0);
    check_val("mr_od", 32'(pad_if.bufod), 32'd0);
    check_val("mr_busy", 32'(busy), 32'd0);
    check_val("mr_cont", 32'(contention), 32'd0);
    reset = 1'b1;
    dir_req = '0; od_req = '0; dout = '0; force_en = '0;
    steps(4);
    $display("mid-operation reset: all outputs cleared");

    // Randomised traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(39, 0) == 0) dir_req[i] = ~dir_req[i];
        if ($urandom_range(19, 0) == 0) od_req[i]  = ~od_req[i];
        if ($urandom_range(3, 0) == 0)  dout[i]    = $urandom_range(1, 0) != 0;
        if ($urandom_range(59, 0) == 0) begin
          force_en[i]  = ~force_en[i];
          force_val[i] = $urandom_range(1, 0) != 0;
        end
        ext_val[i]   = $urandom_range(1, 0) != 0;
        fault_clr[i] = ($urandom_range(29, 0) == 0);
      end
      reset = ($urandom_range(499, 0) != 0);
      step();
      if ((n % 500) == 499)
        $display("random burst %0d: cycle %0d errors=%0d", n / 500, cyc, err_cnt);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
